// File: rtl/ram_if_pkg.sv
// ram_if_pkg: shared definitions for the data-RAM store path.
//   RAM_ADDR_W   - width of the RAM word address
//   SEL_*        - byte-lane select masks (bit i enables byte lane i)
//   store_size_t - store width as decoded from the Sb/Sh controls
package ram_if_pkg;

    localparam int unsigned RAM_ADDR_W = 10;

    localparam logic [3:0] SEL_WORD    = 4'hF;
    localparam logic [3:0] SEL_HALF_LO = 4'h3;
    localparam logic [3:0] SEL_HALF_HI = 4'hC;
    localparam logic [3:0] SEL_BYTE0   = 4'h1;

    typedef enum logic [1:0] {
        WORD,
        HALF,
        BYTE
    } store_size_t;

endpackage

// File: rtl/store_lane_decoder.sv
// store_lane_decoder: combinational byte-lane select for a store.
// Ports:
//   size     - store width (WORD / HALF / BYTE)
//   byte_off - low two bits of the byte address
//   mem_sel  - 4-bit lane select, little-endian (offset k -> lane k)
module store_lane_decoder
    import ram_if_pkg::*;
(
    input  store_size_t size,
    input  logic [1:0]  byte_off,
    output logic [3:0]  mem_sel
);

    always_comb begin
        mem_sel = SEL_WORD;
        case (size)
            WORD:    mem_sel = SEL_WORD;
            // Bit 0 of the offset is dropped for halfwords: no misalignment trap.
            HALF:    mem_sel = byte_off[1] ? SEL_HALF_HI : SEL_HALF_LO;
            BYTE:    mem_sel = SEL_BYTE0 << byte_off;
            default: mem_sel = SEL_WORD;
        endcase
    end

endmodule

// File: rtl/ram_input_adapter.sv
// ram_input_adapter: store-path adapter between execute stage and data RAM.
// Converts a byte address and store data into a registered RAM word address,
// lane-replicated write data and byte-lane select.
// Ports:
//   clk, rst      - clock (rising edge) and synchronous active-high reset
//   result1       - ALU byte address of the store
//   regfile_out2  - store data from register-file read port 2
//   Sh, Sb        - halfword / byte store (Sb wins when both set)
//   addr          - registered RAM word address (result1[11:2])
//   mem_in        - registered RAM write data, replicated across lanes
//   mem_sel       - registered byte-lane select
module ram_input_adapter
    import ram_if_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  result1,
    input  logic [DATA_BITS-1:0]  regfile_out2,
    input  logic                  Sh,
    input  logic                  Sb,
    output logic [RAM_ADDR_W-1:0] addr,
    output logic [DATA_BITS-1:0]  mem_in,
    output logic [3:0]            mem_sel
);

    if (DATA_BITS != 32) begin : g_bad_data_bits
        $error("ram_input_adapter: DATA_BITS must be 32");
    end
    if (ADDR_BITS <= 12) begin : g_bad_addr_bits
        $error("ram_input_adapter: ADDR_BITS must exceed 12");
    end

    store_size_t           size;
    logic [3:0]            sel_d;
    logic [DATA_BITS-1:0]  data_d;
    logic [RAM_ADDR_W-1:0] addr_d;

    // Address bits above the 4 KiB window are intentionally discarded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^result1[ADDR_BITS-1:12];

    always_comb begin
        if (Sb)      size = BYTE;
        else if (Sh) size = HALF;
        else         size = WORD;
    end

    store_lane_decoder u_lane_dec (
        .size     (size),
        .byte_off (result1[1:0]),
        .mem_sel  (sel_d)
    );

    // Replicate the store data so the selected lanes always carry it,
    // whatever the offset.
    always_comb begin
        data_d = regfile_out2;
        case (size)
            HALF:    data_d = {2{regfile_out2[15:0]}};
            BYTE:    data_d = {4{regfile_out2[7:0]}};
            default: data_d = regfile_out2;
        endcase
    end

    assign addr_d = result1[11:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            mem_in  <= '0;
            mem_sel <= '0;
        end else begin
            addr    <= addr_d;
            mem_in  <= data_d;
            mem_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_ram_input_adapter.sv
module tb_ram_input_adapter;

    logic        clk;
    logic        rst;
    logic [31:0] result1;
    logic [31:0] regfile_out2;
    logic        sh;
    logic        sb;
    logic [9:0]  addr;
    logic [31:0] mem_in;
    logic [3:0]  mem_sel;

    int errors = 0;
    int checks = 0;

    ram_input_adapter #(
        .ADDR_BITS (32),
        .DATA_BITS (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result1      (result1),
        .regfile_out2 (regfile_out2),
        .Sh           (sh),
        .Sb           (sb),
        .addr         (addr),
        .mem_in       (mem_in),
        .mem_sel      (mem_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic h, input logic b);
        result1      = a;
        regfile_out2 = d;
        sh           = h;
        sb           = b;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] ea,
                              input logic [31:0] ed, input logic [3:0] es);
        checks++;
        assert (addr === ea) else begin
            errors++;
            $error("FAIL %s addr: got %0h want %0h", tag, addr, ea);
        end
        checks++;
        assert (mem_in === ed) else begin
            errors++;
            $error("FAIL %s mem_in: got %08h want %08h", tag, mem_in, ed);
        end
        checks++;
        assert (mem_sel === es) else begin
            errors++;
            $error("FAIL %s mem_sel: got %04b want %04b", tag, mem_sel, es);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1, 1'b0);
        step();
        step();
        expect_out("reset", 10'h000, 32'h0000_0000, 4'b0000);

        rst = 1'b0;
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        expect_out("word", 10'h004, 32'hDEAD_BEEF, 4'b1111);

        drive(32'h0000_0FFF, 32'h0102_0304, 1'b0, 1'b0);
        step();
        expect_out("word_misaligned", 10'h3FF, 32'h0102_0304, 4'b1111);

        drive(32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0);
        step();
        expect_out("half_hi", 10'h000, 32'h0001_0001, 4'b1100);

        drive(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0);
        step();
        expect_out("half_lo", 10'h000, 32'h0001_0001, 4'b0011);

        drive(32'h0000_0003, 32'hFFFF_5678, 1'b1, 1'b0);
        step();
        expect_out("half_odd", 10'h000, 32'h5678_5678, 4'b1100);

        drive(32'h0000_0004, 32'h0000_1234, 1'b0, 1'b1);
        step();
        expect_out("byte", 10'h001, 32'h3434_3434, 4'b0001);

        drive(32'h0000_0100, 32'h0000_00C3, 1'b0, 1'b1);
        step();
        expect_out("byte_off0", 10'h040, 32'hC3C3_C3C3, 4'b0001);
        drive(32'h0000_0101, 32'h0000_00C3, 1'b0, 1'b1);
        step();
        expect_out("byte_off1", 10'h040, 32'hC3C3_C3C3, 4'b0010);
        drive(32'h0000_0102, 32'h0000_00C3, 1'b0, 1'b1);
        step();
        expect_out("byte_off2", 10'h040, 32'hC3C3_C3C3, 4'b0100);
        drive(32'h0000_0103, 32'h0000_00C3, 1'b0, 1'b1);
        step();
        expect_out("byte_off3", 10'h040, 32'hC3C3_C3C3, 4'b1000);

        drive(32'h0000_1003, 32'h0000_00AB, 1'b1, 1'b1);
        step();
        expect_out("prio_wrap", 10'h000, 32'hABAB_ABAB, 4'b1000);

        // Inputs moving between edges must not reach the outputs early.
        drive(32'h0000_0020, 32'h1111_2222, 1'b0, 1'b0);
        #3;
        expect_out("hold_between_edges", 10'h000, 32'hABAB_ABAB, 4'b1000);
        step();
        expect_out("b2b_word", 10'h008, 32'h1111_2222, 4'b1111);

        drive(32'h0000_0006, 32'h0000_9876, 1'b1, 1'b0);
        step();
        expect_out("b2b_half", 10'h001, 32'h9876_9876, 4'b1100);

        drive(32'h8000_0044, 32'h0000_0000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        expect_out("mid_reset", 10'h000, 32'h0000_0000, 4'b0000);

        rst = 1'b0;
        drive(32'h0000_0008, 32'h0000_BEEF, 1'b1, 1'b0);
        step();
        expect_out("after_reset", 10'h002, 32'hBEEF_BEEF, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
